// File: rtl/cordic_pkg.sv
// Shared constants and FSM state type for the CORDIC phase generator.
// LATENCY tracks the downstream rotator pipeline depth (STAGES + 2).
package cordic_pkg;
  localparam int ANGLE_W    = 16;
  localparam int ANGLE_FULL = 65536;
  localparam int Q1_TH      = ANGLE_FULL / 4;
  localparam int Q2_TH      = ANGLE_FULL / 2;
  localparam int Q3_TH      = (ANGLE_FULL / 4) * 3;
  localparam int STAGES     = 6;
  localparam int LATENCY    = STAGES + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/valid_delay.sv
// DEPTH-cycle shift of a valid strobe, used to align with rotator outputs.
module valid_delay #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_din,
  output logic o_dout
);
  logic [DEPTH-1:0] r_sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_dout = r_sr[DEPTH-1];
endmodule

// File: rtl/cordic_phase_gen.sv
// Phase accumulator feeding a CORDIC rotator: bursts of angles at a divided
// sample rate, then drains the rotator pipeline before signalling done.
module cordic_phase_gen #(
  parameter int RATE_W  = 8,
  parameter int LATENCY = cordic_pkg::LATENCY
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [15:0]        ftw,
  input  logic [15:0]        phase_off,
  input  logic [15:0]        burst_len,
  input  logic [RATE_W-1:0]  rate_div,
  output logic signed [31:0] angle,
  output logic               angle_valid,
  output logic               result_valid,
  output logic               busy,
  output logic               done,
  output logic [1:0]         dbg_state
);
  import cordic_pkg::*;

  localparam int DW = $clog2(LATENCY + 1);

  state_t              r_state;
  logic [15:0]         r_ftw;
  logic [15:0]         r_off;
  logic [15:0]         r_burst;
  logic [RATE_W-1:0]   r_rate;
  logic [RATE_W-1:0]   r_tick_cnt;
  logic [15:0]         r_acc;
  logic [15:0]         r_samp_cnt;
  logic [DW-1:0]       r_drain_cnt;
  logic [15:0]         r_angle;
  logic                r_angle_valid;
  logic                r_busy;
  logic                r_done;
  logic                w_tick;
  logic [15:0]         w_samp_next;
  logic                w_result_valid;

  assign w_tick      = (r_tick_cnt == r_rate);
  assign w_samp_next = r_samp_cnt + 16'd1;

  // stop is checked before the tick so an abort never emits a sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ftw         <= '0;
      r_off         <= '0;
      r_burst       <= '0;
      r_rate        <= '0;
      r_tick_cnt    <= '0;
      r_acc         <= '0;
      r_samp_cnt    <= '0;
      r_drain_cnt   <= '0;
      r_angle       <= '0;
      r_angle_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_angle_valid <= 1'b0;
      r_done        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ftw      <= ftw;
            r_off      <= phase_off;
            r_burst    <= burst_len;
            r_rate     <= rate_div;
            r_acc      <= '0;
            r_samp_cnt <= '0;
            r_tick_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            r_drain_cnt <= DW'(LATENCY);
            r_state     <= S_DRAIN;
          end else if (w_tick) begin
            r_angle       <= r_acc + r_off;
            r_angle_valid <= 1'b1;
            r_acc         <= r_acc + r_ftw;
            r_samp_cnt    <= w_samp_next;
            r_tick_cnt    <= '0;
            if ((r_burst != 16'd0) && (w_samp_next == r_burst)) begin
              r_drain_cnt <= DW'(LATENCY);
              r_state     <= S_DRAIN;
            end
          end else begin
            r_tick_cnt <= r_tick_cnt + RATE_W'(1);
          end
        end
        S_DRAIN: begin
          // done lands on the edge the last sample leaves the delay line
          if (r_drain_cnt <= DW'(1)) begin
            r_drain_cnt <= '0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_drain_cnt <= r_drain_cnt - DW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  valid_delay #(.DEPTH(LATENCY)) u_valid_delay (
    .clk    (clk),
    .reset  (reset),
    .i_din  (r_angle_valid),
    .o_dout (w_result_valid)
  );

  assign angle        = {16'd0, r_angle};
  assign angle_valid  = r_angle_valid;
  assign result_valid = w_result_valid;
  assign busy         = r_busy;
  assign done         = r_done;
  assign dbg_state    = r_state;
endmodule
